// File: rtl/inst_encode_stream_if.sv
// Request/response bundle of the RV32I encoder stream: request in, encoded word out.
// master drives requests and consumes words; slave is the encoder.
interface inst_encode_stream_if #(
   parameter int ADDR_W = 10
) ();
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       operation;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [31:0]       imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_addr;
   logic              err_illegal;
   logic [7:0]        err_count;

   modport master (
      output in_valid, operation, rd, rs1, rs2, imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, err_illegal, err_count
   );

   modport slave (
      input  in_valid, operation, rd, rs1, rs2, imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr, err_illegal, err_count
   );
endinterface

// File: rtl/inst_encode_stream.sv
// Streams one-hot encode requests into RV32I words through a single output register,
// numbering each word with a byte address and counting rejected (non-one-hot) requests.
module inst_encode_stream #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input logic                   clk,
   input logic                   rst,
   inst_encode_stream_if.slave   bus
);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [6:0] OPC_ALUI   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_ALU    = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   logic              r_valid;
   logic [31:0]       r_inst;
   logic [ADDR_W-1:0] r_addr;
   logic              r_err;
   logic [7:0]        r_cnt;

   logic [31:0] w_op;
   logic [31:0] w_imm;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [31:0] w_inst;
   logic        w_onehot;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_legal;
   logic        w_illegal;
   logic        w_consume;

   assign w_op  = bus.operation;
   assign w_imm = bus.imm;
   assign w_rd  = bus.rd;
   assign w_rs1 = bus.rs1;
   assign w_rs2 = bus.rs2;

   // x & (x-1) clears the lowest set bit, so it is zero exactly when at most one bit is set.
   assign w_onehot   = (w_op != '0) && ((w_op & (w_op - 32'd1)) == '0);
   assign w_in_ready = !rst && (!r_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_legal    = w_accept && w_onehot;
   assign w_illegal  = w_accept && !w_onehot;
   assign w_consume  = r_valid && bus.out_ready;

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      w_inst = '0;
      case (1'b1)
         w_op[31]: w_inst = {w_imm[11:0], w_rs1, 3'd0, w_rd, OPC_ALUI};
         w_op[30]: w_inst = {w_imm[11:0], w_rs1, 3'd2, w_rd, OPC_ALUI};
         w_op[29]: w_inst = {w_imm[11:0], w_rs1, 3'd7, w_rd, OPC_ALUI};
         w_op[28]: w_inst = {w_imm[11:0], w_rs1, 3'd6, w_rd, OPC_ALUI};
         w_op[27]: w_inst = {w_imm[11:0], w_rs1, 3'd4, w_rd, OPC_ALUI};
         w_op[26]: w_inst = {w_imm[31:12], w_rd, OPC_LUI};
         w_op[25]: w_inst = {w_imm[31:12], w_rd, OPC_AUIPC};
         w_op[24]: w_inst = {7'h00, w_imm[4:0], w_rs1, 3'd1, w_rd, OPC_ALUI};
         w_op[23]: w_inst = {7'h00, w_imm[4:0], w_rs1, 3'd5, w_rd, OPC_ALUI};
         w_op[22]: w_inst = {7'h20, w_imm[4:0], w_rs1, 3'd5, w_rd, OPC_ALUI};
         w_op[21]: w_inst = {7'h00, w_rs2, w_rs1, 3'd0, w_rd, OPC_ALU};
         w_op[20]: w_inst = {7'h20, w_rs2, w_rs1, 3'd0, w_rd, OPC_ALU};
         w_op[19]: w_inst = {7'h00, w_rs2, w_rs1, 3'd4, w_rd, OPC_ALU};
         w_op[18]: w_inst = {7'h00, w_rs2, w_rs1, 3'd6, w_rd, OPC_ALU};
         w_op[17]: w_inst = {7'h00, w_rs2, w_rs1, 3'd7, w_rd, OPC_ALU};
         w_op[16]: w_inst = {7'h00, w_rs2, w_rs1, 3'd1, w_rd, OPC_ALU};
         w_op[15]: w_inst = {7'h00, w_rs2, w_rs1, 3'd5, w_rd, OPC_ALU};
         w_op[14]: w_inst = {7'h00, w_rs2, w_rs1, 3'd2, w_rd, OPC_ALU};
         w_op[13]: w_inst = {w_imm[11:0], w_rs1, 3'd0, w_rd, OPC_LOAD};
         w_op[12]: w_inst = {w_imm[11:0], w_rs1, 3'd1, w_rd, OPC_LOAD};
         w_op[11]: w_inst = {w_imm[11:0], w_rs1, 3'd2, w_rd, OPC_LOAD};
         w_op[10]: w_inst = {w_imm[11:5], w_rs2, w_rs1, 3'd0, w_imm[4:0], OPC_STORE};
         w_op[9]:  w_inst = {w_imm[11:5], w_rs2, w_rs1, 3'd1, w_imm[4:0], OPC_STORE};
         w_op[8]:  w_inst = {w_imm[11:5], w_rs2, w_rs1, 3'd2, w_imm[4:0], OPC_STORE};
         w_op[7]:  w_inst = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, OPC_JAL};
         w_op[6]:  w_inst = {w_imm[11:0], w_rs1, 3'd0, w_rd, OPC_JALR};
         w_op[5]:  w_inst = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'd0, w_imm[4:1], w_imm[11], OPC_BRANCH};
         w_op[4]:  w_inst = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'd1, w_imm[4:1], w_imm[11], OPC_BRANCH};
         w_op[3]:  w_inst = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'd4, w_imm[4:1], w_imm[11], OPC_BRANCH};
         w_op[2]:  w_inst = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'd5, w_imm[4:1], w_imm[11], OPC_BRANCH};
         w_op[1]:  w_inst = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'd6, w_imm[4:1], w_imm[11], OPC_BRANCH};
         w_op[0]:  w_inst = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'd7, w_imm[4:1], w_imm[11], OPC_BRANCH};
         default:  w_inst = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_inst  <= '0;
         r_addr  <= BASE;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (w_legal) begin
            r_valid <= 1'b1;
            r_inst  <= w_inst;
         end else if (w_consume) begin
            r_valid <= 1'b0;
         end
         // out_addr always names the word currently (or next) in the register.
         if (w_consume) r_addr <= r_addr + ADDR_W'(4);
         r_err <= w_illegal;
         if (w_illegal && (r_cnt != 8'hFF)) r_cnt <= r_cnt + 8'd1;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_valid;
   assign bus.out_inst    = r_inst;
   assign bus.out_addr    = r_addr;
   assign bus.err_illegal = r_err;
   assign bus.err_count   = r_cnt;
endmodule

// File: tb/tb_inst_encode_stream.sv
// Bench for inst_encode_stream: table of encodings streamed through a scoreboard,
// plus stall, reset-while-stalled, illegal-op and address-wrap sequences.
module tb_inst_encode_stream;
   localparam logic [31:0] OP_ADDI  = 32'h8000_0000;
   localparam logic [31:0] OP_ANDI  = 32'h2000_0000;
   localparam logic [31:0] OP_LUI   = 32'h0400_0000;
   localparam logic [31:0] OP_AUIPC = 32'h0200_0000;
   localparam logic [31:0] OP_SLLI  = 32'h0100_0000;
   localparam logic [31:0] OP_SRAI  = 32'h0040_0000;
   localparam logic [31:0] OP_SUB   = 32'h0010_0000;
   localparam logic [31:0] OP_SLT   = 32'h0000_4000;
   localparam logic [31:0] OP_LW    = 32'h0000_0800;
   localparam logic [31:0] OP_SB    = 32'h0000_0400;
   localparam logic [31:0] OP_SW    = 32'h0000_0100;
   localparam logic [31:0] OP_JAL   = 32'h0000_0080;
   localparam logic [31:0] OP_JALR  = 32'h0000_0040;
   localparam logic [31:0] OP_BEQ   = 32'h0000_0020;
   localparam logic [31:0] OP_BNE   = 32'h0000_0010;
   localparam logic [31:0] OP_BGEU  = 32'h0000_0001;

   typedef struct packed {
      logic [31:0] op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] exp;
   } vec_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [9:0]  addr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_words  = 0;
   exp_t sb_q[$];

   inst_encode_stream_if #(.ADDR_W(10)) bus ();
   inst_encode_stream_if #(.ADDR_W(4))  bus4 ();

   inst_encode_stream #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   inst_encode_stream #(.ADDR_W(4), .BASE_ADDR(0)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard: every consumed word must match the oldest expected word.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got word 0x%08h, expected none", bus.out_inst);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_inst", bus.out_inst, e.inst);
            check("sb_addr", 32'(bus.out_addr), 32'(e.addr));
         end
      end
   end

   // Drives one request, waits (bounded) for acceptance and checks the cycle after it.
   task automatic send(input logic [31:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp,
                       input bit legal, output int waits);
      logic exp_v;
      exp_t e;
      bus.operation = op;
      bus.rd        = rd;
      bus.rs1       = rs1;
      bus.rs2       = rs2;
      bus.imm       = imm;
      bus.in_valid  = 1'b1;
      if (legal) begin
         e.inst = exp;
         e.addr = 10'(n_words * 4);
         sb_q.push_back(e);
         n_words++;
      end
      waits = 0;
      @(negedge clk);
      while (!bus.in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", waits);
         bus.in_valid = 1'b0;
         return;
      end
      exp_v = bus.out_valid && !bus.out_ready;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (legal) begin
         check("lat_valid", bus.out_valid, 1);
         check("lat_inst", bus.out_inst, exp);
      end else begin
         check("illegal_pulse", bus.err_illegal, 1);
         check("illegal_valid", bus.out_valid, exp_v);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[16];
      logic [3:0] wrap_a[5];
      int w;

      vecs[0]  = '{op: OP_ADDI,  rd: 1,  rs1: 0,  rs2: 31, imm: 32'd5,          exp: 32'h0050_0093};
      vecs[1]  = '{op: OP_SUB,   rd: 3,  rs1: 1,  rs2: 2,  imm: 32'hFFFF_FFFF,  exp: 32'h4020_81B3};
      vecs[2]  = '{op: OP_SW,    rd: 31, rs1: 1,  rs2: 2,  imm: 32'd8,          exp: 32'h0020_A423};
      vecs[3]  = '{op: OP_BEQ,   rd: 31, rs1: 1,  rs2: 2,  imm: 32'hFFFF_FFFC,  exp: 32'hFE20_8EE3};
      vecs[4]  = '{op: OP_JAL,   rd: 0,  rs1: 31, rs2: 31, imm: 32'd0,          exp: 32'h0000_006F};
      vecs[5]  = '{op: OP_LUI,   rd: 5,  rs1: 31, rs2: 31, imm: 32'h1234_5FFF,  exp: 32'h1234_52B7};
      vecs[6]  = '{op: OP_SRAI,  rd: 2,  rs1: 3,  rs2: 31, imm: 32'hFFFF_FFE7,  exp: 32'h4071_D113};
      vecs[7]  = '{op: OP_ANDI,  rd: 10, rs1: 11, rs2: 31, imm: 32'hFFFF_FFFF,  exp: 32'hFFF5_F513};
      vecs[8]  = '{op: OP_LW,    rd: 5,  rs1: 2,  rs2: 31, imm: 32'hFFFF_FFF8,  exp: 32'hFF81_2283};
      vecs[9]  = '{op: OP_BNE,   rd: 31, rs1: 10, rs2: 0,  imm: 32'd8,          exp: 32'h0005_1463};
      vecs[10] = '{op: OP_JALR,  rd: 1,  rs1: 5,  rs2: 31, imm: 32'h10,         exp: 32'h0102_80E7};
      vecs[11] = '{op: OP_AUIPC, rd: 3,  rs1: 31, rs2: 31, imm: 32'hFFFF_F000,  exp: 32'hFFFF_F197};
      vecs[12] = '{op: OP_SLT,   rd: 4,  rs1: 5,  rs2: 6,  imm: 32'hFFFF_FFFF,  exp: 32'h0062_A233};
      vecs[13] = '{op: OP_SB,    rd: 31, rs1: 8,  rs2: 9,  imm: 32'hFFFF_FFFF,  exp: 32'hFE94_0FA3};
      vecs[14] = '{op: OP_BGEU,  rd: 31, rs1: 1,  rs2: 2,  imm: 32'h800,        exp: 32'h0020_F0E3};
      vecs[15] = '{op: OP_JAL,   rd: 1,  rs1: 31, rs2: 31, imm: 32'h000F_FFFE,  exp: 32'h7FFF_F0EF};
      wrap_a[0] = 4'h0; wrap_a[1] = 4'h4; wrap_a[2] = 4'h8; wrap_a[3] = 4'hC; wrap_a[4] = 4'h0;

      bus.in_valid = 1'b0; bus.operation = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
      bus.imm = '0; bus.out_ready = 1'b1;
      bus4.in_valid = 1'b0; bus4.operation = '0; bus4.rd = '0; bus4.rs1 = '0; bus4.rs2 = '0;
      bus4.imm = '0; bus4.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_inst", bus.out_inst, 0);
      check("rst_out_addr", 32'(bus.out_addr), 0);
      check("rst_err_illegal", bus.err_illegal, 0);
      check("rst_err_count", 32'(bus.err_count), 0);
      check("rst_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Encoding table, streamed back-to-back with the consumer always ready
      for (int i = 0; i < 16; i++) begin
         send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].exp, 1'b1, w);
         check("b2b_no_stall", 32'(w), 0);
      end
      repeat (2) @(posedge clk);
      #1;
      check("table_drained", 32'(sb_q.size()), 0);
      check("table_idle", bus.out_valid, 0);

      // Stall: first word held, second request waits for release
      bus.out_ready = 1'b0;
      send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1, w);
      fork
         send(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b1, w);
         begin
            repeat (3) begin
               @(negedge clk);
               check("stall_in_ready", bus.in_ready, 0);
               check("stall_valid", bus.out_valid, 1);
               check("stall_inst", bus.out_inst, 32'h0050_0093);
               check("stall_addr", 32'(bus.out_addr), 32'(10'((n_words - 2) * 4)));
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      check("stall_wait_cycles", 32'(w), 3);
      repeat (2) @(posedge clk);
      #1;
      check("stall_drained", 32'(sb_q.size()), 0);

      // Reset while a word is stalled, with a request presented during reset
      bus.out_ready = 1'b0;
      send(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd31, 32'h01F0_9093, 1'b1, w);
      rst = 1'b1;
      bus.operation = OP_ADDI; bus.rd = 5'd7; bus.imm = 32'd1; bus.in_valid = 1'b1;
      @(negedge clk);
      check("rst_in_ready_low", bus.in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      sb_q.delete();
      n_words = 0;
      check("rst_stall_valid", bus.out_valid, 0);
      check("rst_stall_addr", 32'(bus.out_addr), 0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rst_no_accept", bus.out_valid, 0);

      // Illegal operation codes
      send(32'h0000_0003, 5'd1, 5'd1, 5'd1, 32'd0, 32'd0, 1'b0, w);
      check("illegal_count_1", 32'(bus.err_count), 1);
      @(posedge clk);
      #1;
      check("illegal_pulse_end", bus.err_illegal, 0);
      check("illegal_no_valid", bus.out_valid, 0);
      send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1, w);
      @(posedge clk);
      #1;
      for (int i = 0; i < 300; i++) begin
         send((i % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, w);
      end
      check("illegal_count_sat", 32'(bus.err_count), 255);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst_err_count_clear", 32'(bus.err_count), 0);

      // Address wrap with a 4-bit address
      for (int i = 0; i < 5; i++) begin
         bus4.operation = OP_ADDI;
         bus4.rd        = 5'(i);
         bus4.in_valid  = 1'b1;
         @(negedge clk);
         check("wrap_in_ready", bus4.in_ready, 1);
         @(posedge clk);
         #1 bus4.in_valid = 1'b0;
         check("wrap_valid", bus4.out_valid, 1);
         check("wrap_addr", 32'(bus4.out_addr), 32'(wrap_a[i]));
      end

      repeat (3) @(posedge clk);
      #1;
      check("final_drained", 32'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
